// File: rtl/icache_pkg.sv
// Shared types, default geometry and address field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  localparam int DEF_INDEX_BITS  = 3;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_MEM_WAIT    = 1;
  localparam int OFF_BITS        = $clog2(DEF_BLOCK_WORDS);
  localparam int TAG_BITS        = 30 - OFF_BITS - DEF_INDEX_BITS;

  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  function automatic logic [31:0] off_of(input logic [31:0] addr, input int off_bits);
    return addr_field(addr, 2, off_bits);
  endfunction

  function automatic logic [31:0] index_of(input logic [31:0] addr, input int off_bits,
                                           input int index_bits);
    return addr_field(addr, off_bits + 2, index_bits);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int off_bits,
                                         input int index_bits);
    return addr >> (off_bits + index_bits + 2);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the cache with a combinational lookup port,
// one refill word-write port and a single-cycle flush of all valid bits.
module icache_line_store #(
  parameter int INDEX_BITS  = 3,
  parameter int BLOCK_WORDS = 4,
  parameter int TAG_W       = 25
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [INDEX_BITS-1:0]          rd_index,
  input  logic [$clog2(BLOCK_WORDS)-1:0] rd_off,
  input  logic [TAG_W-1:0]               rd_tag,
  output logic                           rd_hit,
  output logic [31:0]                    rd_data,
  input  logic                           wr_en,
  input  logic [INDEX_BITS-1:0]          wr_index,
  input  logic [$clog2(BLOCK_WORDS)-1:0] wr_off,
  input  logic [31:0]                    wr_data,
  input  logic                           fill_done,
  input  logic [TAG_W-1:0]               fill_tag
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][BLOCK_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid <= '0;
    else if (flush)     valid <= '0;
    else if (fill_done) valid[wr_index] <= 1'b1;
  end

  // NOTE: tag and data arrays carry no reset; valid alone decides whether
  // their contents are meaningful, so they stay plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en)     data_mem[wr_index][wr_off] <= wr_data;
    if (fill_done) tag_mem[wr_index] <= fill_tag;
  end

  assign rd_hit  = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_data = data_mem[rd_index][rd_off];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: zero-latency hits, stall-and-refill on
// miss one word per beat from InstructionMem, saturating miss counter.
module icache_direct
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int MEM_WAIT    = DEF_MEM_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic        flush,
  output logic        cpu_ready,
  output logic [31:0] cpu_instr,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic [15:0] miss_count
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W = 30 - OFF_W - INDEX_BITS;

  state_t                state, state_n;
  logic [OFF_W-1:0]      beat, off;
  logic [2:0]            wait_cnt;
  logic [INDEX_BITS-1:0] index, lat_index;
  logic [TAG_W-1:0]      tag, lat_tag;
  logic                  rd_hit, wr_en, fill_done, start_miss;
  logic                  beat_end, last_beat;
  logic [31:0]           rd_data;

  assign off   = OFF_W'(off_of(cpu_addr, OFF_W));
  assign index = INDEX_BITS'(index_of(cpu_addr, OFF_W, INDEX_BITS));
  assign tag   = TAG_W'(tag_of(cpu_addr, OFF_W, INDEX_BITS));

  assign beat_end  = (wait_cnt == 3'(MEM_WAIT));
  assign last_beat = (beat == OFF_W'(BLOCK_WORDS - 1));

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .BLOCK_WORDS(BLOCK_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .rd_index (index),
    .rd_off   (off),
    .rd_tag   (tag),
    .rd_hit   (rd_hit),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (lat_index),
    .wr_off   (beat),
    .wr_data  (mem_instr),
    .fill_done(fill_done),
    .fill_tag (lat_tag)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    cpu_ready  = 1'b0;
    cpu_instr  = '0;
    mem_addr   = {cpu_addr[31:2], 2'b00};
    wr_en      = 1'b0;
    fill_done  = 1'b0;
    start_miss = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpu_req && !flush) begin
          if (rd_hit) begin
            cpu_ready = 1'b1;
            cpu_instr = rd_data;
          end else begin
            start_miss = 1'b1;
            state_n    = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        mem_addr = {lat_tag, lat_index, beat, 2'b00};
        // A flush abandons the partial line; the held request re-misses.
        if (flush) begin
          state_n = S_IDLE;
        end else if (beat_end) begin
          wr_en = 1'b1;
          if (last_beat) begin
            fill_done = 1'b1;
            state_n   = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      beat       <= '0;
      wait_cnt   <= '0;
      lat_tag    <= '0;
      lat_index  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_n;
      if (start_miss) begin
        lat_tag   <= tag;
        lat_index <= index;
        beat      <= '0;
        wait_cnt  <= '0;
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end else if (state == S_REFILL && !flush) begin
        if (beat_end) begin
          wait_cnt <= '0;
          beat     <= beat + 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 3'd1;
        end
      end
    end
  end

endmodule
